aes_ctr_seq: RTL and testbench

// Sequencer owning the 128-bit CTR-mode counter register and driving the slice-wise counter FSM.
// The cipher control requests "advance counter by N blocks". The sequencer issues N back-to-back

---
 rtl/aes_ctr_seq.sv | 159 +++++++++++++++
 tb/tb_aes_ctr_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_seq.sv
// aes_ctr_seq: owns the 128-bit CTR-mode counter register and sequences the
// slice-wise counter FSM. It issues N increments per request, serves counter
// slices to the FSM, commits the written-back slices and raises a terminal
// alert on FSM alerts, protocol violations or write-back timeouts.
module aes_ctr_seq #(
   parameter int unsigned CtrWidth      = 128,
   parameter int unsigned SliceSize     = 16,
   parameter int unsigned SliceIdxW     = 3,
   parameter int unsigned CntW          = 4,
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 load_i,
   input  logic [CtrWidth-1:0]  load_value_i,
   input  logic                 req_i,
   input  logic [CntW-1:0]      cnt_i,
   output logic                 ack_o,
   output logic                 busy_o,
   output logic [CtrWidth-1:0]  ctr_o,
   output logic                 alert_o,
   output logic                 fsm_incr_o,
   input  logic                 fsm_ready_i,
   input  logic                 fsm_alert_i,
   input  logic [SliceIdxW-1:0] fsm_slice_idx_i,
   output logic [SliceSize-1:0] fsm_slice_o,
   input  logic [SliceSize-1:0] fsm_slice_i,
   input  logic                 fsm_we_i
);

   localparam int unsigned NumSlices = CtrWidth / SliceSize;
   localparam int unsigned TimerW    = $clog2(TimeoutCycles + 1);

   // Sparse encoding, pairwise Hamming distance >= 3.
   typedef enum logic [5:0] {
      IDLE  = 6'b000000,
      ISSUE = 6'b000111,
      WAIT  = 6'b111000,
      DONE  = 6'b011011,
      ERROR = 6'b101101
   } state_e;

   state_e                state_q, state_d;
   logic [CtrWidth-1:0]   ctr_q, ctr_d;
   logic [CntW-1:0]       remaining_q, remaining_d;
   logic [SliceIdxW-1:0]  we_cnt_q, we_cnt_d;
   logic [TimerW-1:0]     timer_q, timer_d;
   logic                  ack_q, ack_d;
   logic                  busy_q, busy_d;
   logic                  alert_q, alert_d;

   // Serve the slice selected by the FSM from the counter register.
   always_comb begin
      fsm_slice_o = '0;
      for (int unsigned i = 0; i < NumSlices; i++) begin
         if (fsm_slice_idx_i == i[SliceIdxW-1:0]) begin
            fsm_slice_o = ctr_q[i*SliceSize +: SliceSize];
         end
      end
   end

   // Next-state, counter commit, increment bookkeeping and timeout logic.
   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q;
      remaining_d = remaining_q;
      we_cnt_d    = we_cnt_q;
      timer_d     = timer_q;

      case (state_q)
         IDLE: begin
            if (load_i) begin
               ctr_d = load_value_i;
            end else if (req_i) begin
               if (cnt_i == '0) begin
                  state_d = DONE;
               end else begin
                  remaining_d = cnt_i;
                  state_d     = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (fsm_ready_i) begin
               we_cnt_d = '0;
               timer_d  = '0;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (fsm_we_i) begin
               for (int unsigned i = 0; i < NumSlices; i++) begin
                  if (fsm_slice_idx_i == i[SliceIdxW-1:0]) begin
                     ctr_d[i*SliceSize +: SliceSize] = fsm_slice_i;
                  end
               end
               timer_d = '0;
               if (we_cnt_q == SliceIdxW'(NumSlices - 1)) begin
                  we_cnt_d    = '0;
                  remaining_d = remaining_q - 1'b1;
                  state_d     = (remaining_d != '0) ? ISSUE : DONE;
               end else begin
                  we_cnt_d = we_cnt_q + 1'b1;
               end
            end else if (timer_q == TimerW'(TimeoutCycles - 1)) begin
               // This is the TimeoutCycles-th consecutive cycle without a write.
               state_d = ERROR;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         ERROR:   state_d = ERROR;
         default: state_d = ERROR;
      endcase

      // Error entry overrides every state; the counter is frozen on entry.
      if (fsm_alert_i || (fsm_we_i && (state_q != WAIT))) begin
         state_d = ERROR;
      end
      if (state_d == ERROR) begin
         ctr_d = ctr_q;
      end

      ack_d   = (state_d == DONE);
      busy_d  = (state_d == ISSUE) || (state_d == WAIT) || (state_d == DONE);
      alert_d = (state_d == ERROR);
   end

   // State and registered outputs, asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         ctr_q       <= '0;
         remaining_q <= '0;
         we_cnt_q    <= '0;
         timer_q     <= '0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         alert_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         remaining_q <= remaining_d;
         we_cnt_q    <= we_cnt_d;
         timer_q     <= timer_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         alert_q     <= alert_d;
      end
   end

   assign fsm_incr_o = (state_q == ISSUE) && fsm_ready_i;
   assign ack_o      = ack_q;
   assign busy_o     = busy_q;
   assign alert_o    = alert_q;
   assign ctr_o      = ctr_q;

endmodule

// File: tb/tb_aes_ctr_seq.sv
// tb_aes_ctr_seq: directed bench for aes_ctr_seq with a behavioural
// slice-wise counter FSM that answers each increment strobe with eight
// back-to-back slice write-backs (LSB slice first, carry rippling upward).
module tb_aes_ctr_seq;

   logic         clk;
   logic         rst_ni;
   logic         load;
   logic [127:0] load_value;
   logic         req;
   logic [3:0]   cnt;
   logic         ack;
   logic         busy;
   logic [127:0] ctr;
   logic         alert;
   logic         incr;
   logic         fsm_ready;
   logic         fsm_alert;
   logic [2:0]   slice_idx;
   logic [15:0]  slice_out;
   logic [15:0]  slice_in;
   logic         emu_we;
   logic         stray_we;
   logic         fsm_we;
   logic         emu_en;

   int passed = 0;
   int total  = 0;
   int incr_seen = 0;
   int we_seen   = 0;

   assign fsm_we = emu_we | stray_we;

   aes_ctr_seq #(
      .CtrWidth(128), .SliceSize(16), .SliceIdxW(3), .CntW(4), .TimeoutCycles(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .load_i(load), .load_value_i(load_value),
      .req_i(req), .cnt_i(cnt), .ack_o(ack), .busy_o(busy), .ctr_o(ctr),
      .alert_o(alert), .fsm_incr_o(incr), .fsm_ready_i(fsm_ready),
      .fsm_alert_i(fsm_alert), .fsm_slice_idx_i(slice_idx), .fsm_slice_o(slice_out),
      .fsm_slice_i(slice_in), .fsm_we_i(fsm_we)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural counter FSM: on a sampled strobe, write all slices back.
   initial begin
      logic carry;
      emu_we    = 1'b0;
      slice_idx = '0;
      slice_in  = '0;
      forever begin
         @(negedge clk);
         if (incr && emu_en) begin
            incr_seen++;
            carry = 1'b1;
            @(posedge clk);
            for (int s = 0; s < 8; s++) begin
               #1;
               slice_idx = 3'(s);
               #1;
               {carry, slice_in} = {1'b0, slice_out} + 17'(carry);
               emu_we = 1'b1;
               @(posedge clk);
               we_seen++;
            end
            #1 emu_we = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   task automatic do_load(input logic [127:0] v);
      @(posedge clk); #1;
      load = 1'b1;
      load_value = v;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   // Called at the drive point of acceptance cycle 0; waits for ack, then drops req.
   task automatic wait_ack(input int load_cyc, input int stall, output int lat,
                           output logic [127:0] ctr_ack, output logic incr2);
      lat = -1;
      ctr_ack = '0;
      incr2 = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         load = (cyc == load_cyc);
         if (cyc == stall) fsm_ready = 1'b1;
         @(negedge clk);
         if (cyc == 2) incr2 = incr;
         if (ack) begin
            lat = cyc;
            ctr_ack = ctr;
            break;
         end
         @(posedge clk); #1;
      end
      load = 1'b0;
      fsm_ready = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic run_req(input logic [3:0] n, input int load_cyc, input int stall,
                          output int lat, output logic [127:0] ctr_ack, output logic incr2);
      @(posedge clk); #1;
      req = 1'b1;
      cnt = n;
      wait_ack(load_cyc, stall, lat, ctr_ack, incr2);
   endtask

   initial begin
      int           lat;
      int           i0;
      int           w0;
      logic [127:0] ca;
      logic         i2;
      logic         seen_ack;
      logic [127:0] v;

      rst_ni = 1'b0; load = 1'b0; load_value = '0; req = 1'b0; cnt = '0;
      fsm_ready = 1'b1; fsm_alert = 1'b0; stray_we = 1'b0; emu_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ctr", ctr, 128'h0);
      check("rst_outs", {ack, busy, alert, incr}, 4'b0000);
      check("rst_slice", slice_out, 16'h0);
      @(posedge clk); #1 rst_ni = 1'b1;

      // T1: 0 + 1
      do_load(128'h0);
      i0 = incr_seen; w0 = we_seen;
      run_req(4'd1, -1, 0, lat, ca, i2);
      check("t1_lat", 128'(lat), 128'd10);
      check("t1_ctr", ca, 128'h1);
      check("t1_incr", 128'(incr_seen - i0), 128'd1);
      check("t1_we", 128'(we_seen - w0), 128'd8);
      @(negedge clk);
      check("t1_ack_pulse", ack, 1'b0);
      check("t1_alert", alert, 1'b0);

      // T2: 0x0000FFFF + 3
      do_load(128'h0000_FFFF);
      i0 = incr_seen;
      run_req(4'd3, -1, 0, lat, ca, i2);
      check("t2_lat", 128'(lat), 128'd28);
      check("t2_ctr", ca, 128'h0001_0002);
      check("t2_incr", 128'(incr_seen - i0), 128'd3);

      // T3: wrap-around, then zero-increment request
      do_load('1);
      run_req(4'd1, -1, 0, lat, ca, i2);
      check("t3_wrap_ctr", ca, 128'h0);
      check("t3_wrap_alert", alert, 1'b0);
      i0 = incr_seen;
      run_req(4'd0, -1, 0, lat, ca, i2);
      check("t3_cnt0_lat", 128'(lat), 128'd1);
      check("t3_cnt0_ctr", ca, 128'h0);
      check("t3_cnt0_incr", 128'(incr_seen - i0), 128'd0);

      // T4: load and req in the same IDLE cycle; load has priority
      v = 128'h0123_4567_89AB_CDEF_0011_2233_4455_FFFF;
      @(posedge clk); #1;
      load = 1'b1; load_value = v; req = 1'b1; cnt = 4'd1;
      @(negedge clk);
      check("t4_busy_load", busy, 1'b0);
      @(posedge clk); #1;
      load = 1'b0;
      @(negedge clk);
      check("t4_ctr_loaded", ctr, v);
      check("t4_busy_cyc0", busy, 1'b0);
      @(posedge clk); #1;
      wait_ack(-1, 0, lat, ca, i2);
      check("t4_lat", 128'(lat), 128'd9);
      check("t4_ctr", ca, 128'h0123_4567_89AB_CDEF_0011_2233_4456_0000);
      // ready stalled in ISSUE, load during WAIT ignored
      load_value = '0;
      fsm_ready = 1'b0;
      run_req(4'd1, 6, 3, lat, ca, i2);
      check("t4_stall_incr", i2, 1'b0);
      check("t4_stall_lat", 128'(lat), 128'd12);
      check("t4_wait_load_ctr", ca, 128'h0123_4567_89AB_CDEF_0011_2233_4456_0001);

      // T5: FSM alert during WAIT
      do_load(128'h0);
      @(posedge clk); #1;
      req = 1'b1; cnt = 4'd1;
      repeat (3) @(posedge clk);
      #1 fsm_alert = 1'b1;
      @(posedge clk); #1 fsm_alert = 1'b0;
      @(negedge clk);
      check("t5_alert", alert, 1'b1);
      check("t5_busy_ack", {busy, ack}, 2'b00);
      check("t5_ctr_frozen", ctr, 128'h1);
      @(posedge clk); #1;
      load = 1'b1; load_value = '1;
      seen_ack = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen_ack = seen_ack | ack;
      end
      load = 1'b0; req = 1'b0;
      check("t5_no_ack", seen_ack, 1'b0);
      check("t5_alert_sticky", alert, 1'b1);
      check("t5_ctr_after", ctr, 128'h1);
      @(posedge clk); #1 rst_ni = 1'b0;
      @(negedge clk);
      check("t5_rst_alert", alert, 1'b0);
      @(posedge clk); #1 rst_ni = 1'b1;

      // T6a: write-back timeout
      emu_en = 1'b0;
      @(posedge clk); #1;
      req = 1'b1; cnt = 4'd1;
      repeat (18) @(negedge clk);
      check("t6_pre_timeout", {alert, busy}, 2'b01);
      @(negedge clk);
      check("t6_timeout", {alert, busy}, 2'b10);
      req = 1'b0;
      @(posedge clk); #1 rst_ni = 1'b0;
      @(posedge clk); #1 rst_ni = 1'b1;
      emu_en = 1'b1;

      // T6b: stray write strobe in IDLE
      @(posedge clk); #1 stray_we = 1'b1;
      @(posedge clk); #1 stray_we = 1'b0;
      @(negedge clk);
      check("t6_stray_we", alert, 1'b1);
      @(posedge clk); #1 rst_ni = 1'b0;
      @(posedge clk); #1 rst_ni = 1'b1;

      // T6c: reset in the middle of WAIT
      do_load(128'h5);
      @(posedge clk); #1;
      req = 1'b1; cnt = 4'd1;
      repeat (4) @(posedge clk);
      #1 rst_ni = 1'b0;
      #1;
      check("t6_rst_ctr", ctr, 128'h0);
      check("t6_rst_outs", {ack, busy, alert}, 3'b000);
      req = 1'b0;
      repeat (12) @(posedge clk);
      #1 rst_ni = 1'b1;
      seen_ack = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen_ack = seen_ack | ack;
      end
      check("t6_rst_no_ack", seen_ack, 1'b0);
      check("t6_rst_alert", alert, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
